// File: rtl/arb_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int NREQ  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick_16.sv
// Round-robin winner search: first set request at or after ptr, wrapping 15->0.
// Latency: purely combinational.
// Backpressure: none; win_vld low when no request is set.
module rr_pick_16
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [NREQ-1:0]  rot;
    logic [IDX_W-1:0] off;

    // Rotate so that bit ptr lands at position 0; the doubled vector makes the wrap free.
    assign rot = NREQ'({req, req} >> ptr);

    // Lowest set bit of the rotated vector is the offset from ptr to the winner.
    always_comb begin
        off     = '0;
        win_vld = |rot;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    // Undo the rotation; 4-bit addition wraps modulo 16.
    assign win_idx = ptr + off;

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with hold-while-requested grants and a dead GAP cycle on release.
// Latency: request in IDLE -> registered grant after 1 edge; release -> next grant earliest 3 edges later.
// Backpressure: enable low blocks new grants and drops the current one; optional ARB_TIMEOUT_EN forces release.
module rr_arbiter_16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_vld,
    output logic              timeout
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic             vld_q, vld_nxt;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt, hold_nxt;
    logic       to_q, to_nxt;
`endif

    rr_pick_16 u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Next-state and next-output logic; other requesters are ignored while BUSY.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx_q;
        vld_nxt   = vld_q;
`ifdef ARB_TIMEOUT_EN
        hold_nxt  = hold_cnt;
        to_nxt    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (enable && win_vld) begin
                    state_nxt = ST_BUSY;
                    idx_nxt   = win_idx;
                    vld_nxt   = 1'b1;
                    ptr_nxt   = win_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            ST_BUSY: begin
                // A voluntary release wins over the hold limit, so timeout stays quiet then.
                if (!enable || !req[idx_q]) begin
                    state_nxt = ST_GAP;
                    vld_nxt   = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_LIM) begin
                    state_nxt = ST_GAP;
                    vld_nxt   = 1'b0;
                    to_nxt    = 1'b1;
                end else begin
                    hold_nxt  = hold_cnt + 8'd1;
                end
`endif
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // State, priority pointer and registered grant; reset wins even mid-grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            idx_q <= idx_nxt;
            vld_q <= vld_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and the registered forced-release pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            hold_cnt <= hold_nxt;
            to_q     <= to_nxt;
        end
    end

    assign timeout = to_q;
`else
    // Without the hold limit no owner is ever forced out; constant 0 for any legal MAX_HOLD.
    assign timeout = (MAX_HOLD == 0);
`endif

    // One-hot grant decoded from the registered index, so it can never carry two bits.
    assign grant     = vld_q ? (NREQ'(1) << idx_q) : '0;
    assign grant_idx = idx_q;
    assign grant_vld = vld_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed scenarios plus random traffic against a reference model.
// Latency: model advances once per rising edge; outputs compared on the falling edge.
// Backpressure: exercises enable drops and, with ARB_TIMEOUT_EN, the forced release.
module tb_rr_arbiter_16;

`ifdef ARB_TIMEOUT_EN
    localparam int MH     = 4;
    localparam bit TO_ON  = 1'b1;
`else
    localparam int MH     = 64;
    localparam bit TO_ON  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_vld;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the resource, how long until arbitration may run again,
    // which client currently has top priority, and how many extra cycles the owner has held.
    int m_owner = -1;
    int m_cool  = 0;
    int m_prio  = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arbiter_16 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT samples, then compare mid-cycle.
    task automatic step();
        bit found;
        int w;
        @(posedge clk);
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_cool  = 0;
            m_prio  = 0;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            if (!enable || !req[m_owner]) begin
                m_owner = -1;
                m_cool  = 1;
            end else if (TO_ON && (m_held == MH - 1)) begin
                m_owner = -1;
                m_cool  = 1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (enable && (req != 16'h0)) begin
            found = 1'b0;
            for (int k = 0; k < 16; k++) begin
                w = (m_prio + k) % 16;
                if (!found && req[w]) begin
                    found   = 1'b1;
                    m_owner = w;
                end
            end
            m_prio = (m_owner + 1) % 16;
            m_held = 0;
        end
        @(negedge clk);
        chk("grant", 32'(grant), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
        chk("grant_vld", 32'(grant_vld), (m_owner >= 0) ? 32'h1 : 32'h0);
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_owner >= 0) begin
            chk("grant_idx", 32'(grant_idx), 32'(m_owner));
        end
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        while (!grant_vld && n < budget) begin
            step();
            n++;
        end
        chk("wait_grant", 32'(grant_vld), 32'h1);
    endtask

    task automatic go_idle();
        req = 16'h0;
        step();
        step();
    endtask

    initial begin
        int held;
        rst    = 1'b1;
        enable = 1'b0;
        req    = 16'h0;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_vld", 32'(grant_vld), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        chk("rst_tmo", 32'(timeout), 32'h0);
        rst    = 1'b0;
        enable = 1'b1;

        // Reset while client 5 owns; afterwards ptr is 0 so client 0 beats client 5.
        req = 16'h0020;
        wait_grant(4);
        chk("t1_own5", 32'(grant_idx), 32'd5);
        step();
        rst = 1'b1;
        step();
        chk("t1_rst_grant", 32'(grant), 32'h0);
        chk("t1_rst_vld", 32'(grant_vld), 32'h0);
        rst = 1'b0;
        req = 16'h0021;
        step();
        chk("t1_first_idx", 32'(grant_idx), 32'd0);
        chk("t1_first_grant", 32'(grant), 32'h0001);

        // Single requester: grant, release, regrant after the dead cycle.
        go_idle();
        req = 16'h0008;
        step();
        chk("t2_grant", 32'(grant), 32'h0008);
        chk("t2_idx", 32'(grant_idx), 32'd3);
        req = 16'h0;
        step();
        chk("t2_release", 32'(grant), 32'h0);
        req = 16'h0008;
        step();
        chk("t2_gap", 32'(grant_vld), 32'h0);
        step();
        chk("t2_regrant", 32'(grant), 32'h0008);

        // Everyone requesting: strict rotation 0..15 then wrap to 0.
        go_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            wait_grant(4);
            chk("t3_rot_idx", 32'(grant_idx), 32'(k % 16));
            step();
            req[k % 16] = 1'b0;
            step();
            req = 16'hFFFF;
        end

        // Pointer wrap: after 14, 15 beats 0, then 0.
        go_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 16'h4000;
        wait_grant(4);
        chk("t4_own14", 32'(grant_idx), 32'd14);
        req = 16'h8001;
        step();
        wait_grant(4);
        chk("t4_own15", 32'(grant_idx), 32'd15);
        req = 16'h0001;
        step();
        wait_grant(4);
        chk("t4_own0", 32'(grant_idx), 32'd0);

        // Enable drop during client 7's ownership.
        go_idle();
        req = 16'h0080;
        wait_grant(4);
        chk("t5_own7", 32'(grant_idx), 32'd7);
        enable = 1'b0;
        req    = 16'hFFFF;
        step();
        chk("t5_drop", 32'(grant), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_blocked", 32'(grant_vld), 32'h0);
        end
        enable = 1'b1;
        wait_grant(4);
        chk("t5_resume_idx", 32'(grant_idx), 32'd8);

        // Hold limit: client 2 keeps requesting while 9 waits.
        go_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 16'h0004;
        wait_grant(4);
        chk("t6_own2", 32'(grant_idx), 32'd2);
        req = 16'h0204;
`ifdef ARB_TIMEOUT_EN
        held = 0;
        while (grant_vld && held < 20) begin
            held++;
            step();
        end
        chk("t6_held", 32'(held), 32'd4);
        chk("t6_pulse", 32'(timeout), 32'h1);
        wait_grant(4);
        chk("t6_next9", 32'(grant_idx), 32'd9);
`else
        held = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (grant_vld && grant_idx == 4'd2) begin
                held++;
            end
        end
        chk("t6_held_forever", 32'(held), 32'd20);
        chk("t6_no_tmo", 32'(timeout), 32'h0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 19) != 0);
            case ($urandom_range(0, 3))
                0:       req = 16'($urandom) & 16'($urandom);
                1:       req = req ^ (16'h1 << $urandom_range(0, 15));
                default: req = req;
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
